// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_NUM_STAGES    = 3;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_STAGE_GAP     = 16;
  localparam int unsigned LOCK_CNT_W        = 16;

  // Counter width for a terminal count parameter, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Debounces MMCM lock and releases staged module resets in order, counting lock-loss events.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = DEF_NUM_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP     = DEF_STAGE_GAP
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reset_strobe_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  done_o,
  output logic [LOCK_CNT_W-1:0] lock_loss_cnt_o
);

  localparam int unsigned STABLE_W = cnt_width(STABLE_CYCLES);
  localparam int unsigned GAP_W    = cnt_width(STAGE_GAP);
  localparam int unsigned IDX_W    = cnt_width(NUM_STAGES);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_STAGES - 1);

  logic s;

  seq_state_e            state_q, state_d;
  logic [STABLE_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  done_q, done_d;
  logic                  s_prev_q;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  // Strobe idles high through reset so power-up never looks like a new lock loss.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (reset_strobe_i),
    .q_o  (s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= HOLD;
      stable_cnt_q <= '0;
      gap_cnt_q    <= '0;
      idx_q        <= '0;
      stage_rst_q  <= '1;
      done_q       <= 1'b0;
      s_prev_q     <= 1'b1;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      idx_q        <= idx_d;
      stage_rst_q  <= stage_rst_d;
      done_q       <= done_d;
      s_prev_q     <= s;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  // Next-state, counters and registered output values.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    idx_d        = idx_q;
    stage_rst_d  = stage_rst_q;
    done_d       = done_q;

    if (s && (state_q != HOLD)) begin
      state_d      = HOLD;
      stable_cnt_d = '0;
      gap_cnt_d    = '0;
      idx_d        = '0;
      stage_rst_d  = '1;
      done_d       = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          stage_rst_d  = '1;
          done_d       = 1'b0;
          stable_cnt_d = '0;
          gap_cnt_d    = '0;
          idx_d        = '0;
          if (!s) begin
            state_d = STABLE;
          end
        end
        STABLE: begin
          stage_rst_d = '1;
          done_d      = 1'b0;
          if (stable_cnt_q == STABLE_LAST) begin
            state_d      = RELEASE;
            stable_cnt_d = '0;
            idx_d        = '0;
            gap_cnt_d    = '0;
          end else begin
            stable_cnt_d = stable_cnt_q + STABLE_W'(1);
          end
        end
        RELEASE: begin
          for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (IDX_W'(i) == idx_q) stage_rst_d[i] = 1'b0;
          end
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else if (gap_cnt_q == GAP_LAST) begin
            idx_d     = idx_q + IDX_W'(1);
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        DONE: begin
          stage_rst_d = '0;
          done_d      = 1'b1;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  // Saturating count of synchronized strobe rising edges.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (s && !s_prev_q && (lock_cnt_q != '1)) begin
      lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
    end
  end

  assign stage_rst_o     = stage_rst_q;
  assign done_o          = done_q;
  assign lock_loss_cnt_o = lock_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (3 stages, 8 stable cycles, gap 4).
module tb_reset_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [2:0]  stage_rst;
  logic        done;
  logic [15:0] lock_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES   (3),
    .STABLE_CYCLES(8),
    .STAGE_GAP    (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .reset_strobe_i (strobe),
    .stage_rst_o    (stage_rst),
    .done_o         (done),
    .lock_loss_cnt_o(lock_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past n rising edges, landing 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after E0; checks the full release schedule up to done.
  task automatic release_seq(input string pfx);
    tick(10);
    chk({pfx, "_e10_stage"}, 32'(stage_rst), 32'h7);
    tick(1);
    chk({pfx, "_e11_stage"}, 32'(stage_rst), 32'h6);
    tick(3);
    chk({pfx, "_e14_stage"}, 32'(stage_rst), 32'h6);
    tick(1);
    chk({pfx, "_e15_stage"}, 32'(stage_rst), 32'h4);
    tick(3);
    chk({pfx, "_e18_stage"}, 32'(stage_rst), 32'h4);
    tick(1);
    chk({pfx, "_e19_stage"}, 32'(stage_rst), 32'h0);
    chk({pfx, "_e19_done"}, 32'(done), 32'h0);
    tick(1);
    chk({pfx, "_e20_done"}, 32'(done), 32'h1);
    chk({pfx, "_e20_stage"}, 32'(stage_rst), 32'h0);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      strobe = 1'b1;
      tick(4);
      strobe = 1'b0;
      tick(4);
    end
  endtask

  initial begin
    rst    = 1'b1;
    strobe = 1'b1;
    tick(4);
    chk("rst_stage", 32'(stage_rst), 32'h7);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cnt", 32'(lock_cnt), 32'h0);

    // Clean power-up
    rst    = 1'b0;
    strobe = 1'b0;
    tick(1);
    release_seq("pu");
    chk("pu_cnt", 32'(lock_cnt), 32'h0);

    // Glitch during STABLE restarts the window from the falling edge
    rst = 1'b1;
    tick(2);
    rst    = 1'b0;
    strobe = 1'b0;
    tick(5);
    strobe = 1'b1;
    tick(2);
    strobe = 1'b0;
    tick(1);
    chk("gl_e0_stage", 32'(stage_rst), 32'h7);
    release_seq("gl");
    chk("gl_cnt", 32'(lock_cnt), 32'h1);

    // Lock loss while in DONE
    strobe = 1'b1;
    tick(4);
    chk("ld_stage", 32'(stage_rst), 32'h7);
    chk("ld_done", 32'(done), 32'h0);
    chk("ld_cnt", 32'(lock_cnt), 32'h2);

    // Lock loss mid-release: stage 0 out, stage 1 still held
    strobe = 1'b0;
    tick(1);
    tick(11);
    chk("mr_pre_stage", 32'(stage_rst), 32'h6);
    strobe = 1'b1;
    tick(4);
    chk("mr_stage", 32'(stage_rst), 32'h7);
    chk("mr_done", 32'(done), 32'h0);
    chk("mr_cnt", 32'(lock_cnt), 32'h3);
    strobe = 1'b0;
    tick(1);
    release_seq("mr");

    // Synchronous reset while in DONE
    rst = 1'b1;
    tick(1);
    chk("rd_stage", 32'(stage_rst), 32'h7);
    chk("rd_done", 32'(done), 32'h0);
    chk("rd_cnt", 32'(lock_cnt), 32'h0);
    rst = 1'b0;
    tick(1);

    // Saturation: preload near the top, then count through the limit
    force dut.lock_cnt_q = 16'hFFFA;
    tick(1);
    release dut.lock_cnt_q;
    tick(1);
    chk("sat_preload", 32'(lock_cnt), 32'hFFFA);
    pulses(3);
    chk("sat_fffd", 32'(lock_cnt), 32'hFFFD);
    pulses(1);
    chk("sat_fffe", 32'(lock_cnt), 32'hFFFE);
    pulses(1);
    chk("sat_ffff", 32'(lock_cnt), 32'hFFFF);
    pulses(4);
    chk("sat_hold", 32'(lock_cnt), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

- Consumes the active-high reset strobe produced from MMCM lock loss.
- Debounces the strobe: lock must be stable for a programmable time before anything is released.
- Releases a vector of staged reset outputs one stage at a time, in order, with a programmable gap between stages. Typical order: core, then fabric, then links.
- Sits directly downstream of the reset strobe generator. Drives the module-level resets of the readout design.
- Reports completion and keeps a count of lock-loss events.

## Interface
Parameters:
- NUM_STAGES, 3: number of staged reset outputs; must be ≥1.
- STABLE_CYCLES, 1024: cycles the strobe must stay low before stage 0 is released; must be ≥1.
- STAGE_GAP, 16: cycles between consecutive stage releases; must be ≥1.

Ports:
- clk_i  input  1  single clock. All logic is in this domain.
- rst_i  input  1  reset; synchronous, active-high.
- reset_strobe_i  input  1  strobe from lock logic; asynchronous to clk_i; high means clock not locked.
- stage_rst_o  output  NUM_STAGES  per-stage reset, active-high; bit 0 is released first.
- done_o  output  1  high when all stages are released.
- lock_loss_cnt_o  output  16  saturating count of strobe rising edges seen after synchronization.

## Operation
- reset_strobe_i passes through a 2-flop synchronizer. Both flops reset to 1. The synchronizer output is called s.
- FSM states: HOLD, STABLE, RELEASE, DONE.
- HOLD:
  - All stage_rst_o bits are 1; done_o is 0.
  - When s is sampled 0, go to STABLE and clear the stable counter.
- STABLE:
  - The stable counter increments every cycle.
  - On count == STABLE_CYCLES-1, go to RELEASE with stage index 0 and gap counter 0.
- RELEASE:
  - Clear stage_rst_o[idx].
  - If idx == NUM_STAGES-1, go to DONE.
  - Otherwise wait STAGE_GAP cycles, then increment idx.
- DONE:
  - done_o is 1 and all stage_rst_o bits are 0.
  - Stay until s goes high.
- s high in any state other than HOLD:
  - Next cycle the state is HOLD, all stage_rst_o are 1 and done_o is 0.
  - All counters restart; there is no partial resume.
- lock_loss_cnt_o:
  - Increments on each 0→1 transition of s and saturates at 0xFFFF.
  - The power-up assertion does not count, because the synchronizer resets to 1.
- rst_i has priority over everything. It returns the FSM to HOLD, sets both synchronizer flops to 1 and clears all counters, including lock_loss_cnt_o.
- Counter widths are $clog2 of the parameter values, minimum 1 bit. Counters never wrap; they are compared and then cleared.

## Timing
- Reset values:
  - stage_rst_o = all ones
  - done_o = 0
  - lock_loss_cnt_o = 0
  - FSM = HOLD
- All outputs are registered.
- Release latency. Let E0 be the first rising edge at which reset_strobe_i is sampled 0 and stays 0:
  - stage_rst_o[0] goes low after edge E0+STABLE_CYCLES+3.
  - stage_rst_o[k] goes low after edge E0+STABLE_CYCLES+3+k·STAGE_GAP.
  - done_o goes high one cycle after the last stage is released.
- Re-assertion latency: a strobe high sampled at edge E goes through the 2 synchronizer flops, so s is high after E+2. All stage_rst_o are high and done_o is low after E+3.
- Strobe pulses shorter than one clk_i period may be missed. This is acceptable, because lock loss lasts many cycles.
- Strobe toggling during STABLE restarts the full STABLE_CYCLES window each time.

## Structure
- Package reset_seq_pkg holds:
  - the state enum typedef (HOLD, STABLE, RELEASE, DONE);
  - default parameter constants;
  - the counter width constant LOCK_CNT_W = 16.
- One sub-module: sync_2ff, a generic single-bit 2-flop synchronizer with a parameterized reset value. It is instantiated once, with reset value 1.
- The FSM and counters live in reset_sequencer itself.

## Test plan
All scenarios use NUM_STAGES=3, STABLE_CYCLES=8, STAGE_GAP=4.
- Clean power-up: rst_i high for 4 cycles, then strobe driven 0 from E0 → stage_rst_o low at E0+11 (bit 0), E0+15 (bit 1), E0+19 (bit 2); done_o=1 at E0+20; lock_loss_cnt_o=0.
- Glitch during STABLE: strobe high for 2 cycles at E0+5 → all stage_rst_o stay 1; the release window restarts from the strobe falling edge; lock_loss_cnt_o=1.
- Lock loss in DONE: strobe high at E → stage_rst_o=3'b111 and done_o=0 after E+3; lock_loss_cnt_o increments by 1.
- Lock loss mid-RELEASE (bit 0 released, bit 1 not yet): stage_rst_o returns to 3'b111 after E+3; the sequence then restarts from stage 0.
- rst_i asserted in DONE → next cycle stage_rst_o=3'b111, done_o=0, lock_loss_cnt_o=0.
- Saturation: 70000 strobe pulses, each 4 cycles high and 4 cycles low → lock_loss_cnt_o=0xFFFF and holds.
